// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
// Module  : control_pkg
// Brief   : Shared RV32I decode constants, control bundle type, rs-usage helper
// Revision: 1.0 - initial registered decode stage release
// ============================================================================
package control_pkg;

    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_IMM    = 7'b0010011;
    localparam logic [6:0] c_OPC_REG    = 7'b0110011;

    localparam logic [3:0] c_ALU_ADD   = 4'd0;
    localparam logic [3:0] c_ALU_SUB   = 4'd1;
    localparam logic [3:0] c_ALU_SLL   = 4'd2;
    localparam logic [3:0] c_ALU_SLT   = 4'd3;
    localparam logic [3:0] c_ALU_SLTU  = 4'd4;
    localparam logic [3:0] c_ALU_XOR   = 4'd5;
    localparam logic [3:0] c_ALU_SRL   = 4'd6;
    localparam logic [3:0] c_ALU_SRA   = 4'd7;
    localparam logic [3:0] c_ALU_OR    = 4'd8;
    localparam logic [3:0] c_ALU_AND   = 4'd9;
    localparam logic [3:0] c_ALU_PASSB = 4'd10;

    // Branch comparison codes equal the branch funct3 encoding.
    localparam logic [2:0] c_BR_EQ  = 3'b000;
    localparam logic [2:0] c_BR_NE  = 3'b001;
    localparam logic [2:0] c_BR_LT  = 3'b100;
    localparam logic [2:0] c_BR_GE  = 3'b101;
    localparam logic [2:0] c_BR_LTU = 3'b110;
    localparam logic [2:0] c_BR_GEU = 3'b111;

    localparam logic [1:0] c_MEM_BYTE = 2'b00;
    localparam logic [1:0] c_MEM_HALF = 2'b01;
    localparam logic [1:0] c_MEM_WORD = 2'b10;

    localparam int c_CTRL_W = 22;

    typedef struct packed {
        logic       branch_enable;
        logic [2:0] branch_mode;
        logic       mem_write_enable;
        logic       mem_unsigned;
        logic [1:0] mem_mode;
        logic       reg_write_enable;
        logic       mem_to_reg;
        logic [3:0] alu_op;
        logic       alu_src;
        logic       pc_to_reg;
        logic       jump_enable;
        logic       jump_reg;
        logic       muldiv_en;
        logic [2:0] muldiv_op;
    } ctrl_t;

    // Returns {rs1_used, rs2_used}; unknown opcodes count as reading rs1.
    function automatic logic [1:0] rs_usage(input logic [6:0] opcode);
        logic rs1_used;
        logic rs2_used;
        rs1_used = !(opcode == c_OPC_LUI || opcode == c_OPC_AUIPC || opcode == c_OPC_JAL);
        rs2_used = (opcode == c_OPC_BRANCH || opcode == c_OPC_STORE || opcode == c_OPC_REG);
        return {rs1_used, rs2_used};
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// ============================================================================
// Module  : control_decode
// Brief   : Combinational RV32I instruction to control bundle decoder.
//           CONTROL_PIPE_RV32M_EN makes the M-extension OP encodings legal.
// Revision: 1.0 - initial registered decode stage release
// ============================================================================
module control_decode
    import control_pkg::*;
#(
    parameter int LWU_LEGAL = 0
) (
    input  logic [31:0]         instr,
    output logic [c_CTRL_W-1:0] ctrl,
    output logic [4:0]          rd,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic                rs1_used,
    output logic                rs2_used,
    output logic                illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    ctrl_t      w_c;
    logic       w_illegal;

    assign w_opcode = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_f7     = instr[31:25];

    // alt selects SUB/SRA for the funct7[5]=1 variants.
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  return c_ALU_SLL;
            3'b010:  return c_ALU_SLT;
            3'b011:  return c_ALU_SLTU;
            3'b100:  return c_ALU_XOR;
            3'b101:  return alt ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  return c_ALU_OR;
            default: return c_ALU_AND;
        endcase
    endfunction

    always_comb begin
        w_c       = '0;
        w_illegal = 1'b0;
        case (w_opcode)
            c_OPC_LUI: begin
                w_c.reg_write_enable = 1'b1;
                w_c.alu_src          = 1'b1;
                w_c.alu_op           = c_ALU_PASSB;
            end
            c_OPC_AUIPC: begin
                w_c.reg_write_enable = 1'b1;
                w_c.alu_src          = 1'b1;
                w_c.alu_op           = c_ALU_ADD;
            end
            c_OPC_JAL: begin
                w_c.reg_write_enable = 1'b1;
                w_c.pc_to_reg        = 1'b1;
                w_c.jump_enable      = 1'b1;
            end
            c_OPC_JALR: begin
                w_c.reg_write_enable = 1'b1;
                w_c.pc_to_reg        = 1'b1;
                w_c.jump_enable      = 1'b1;
                w_c.jump_reg         = 1'b1;
                w_c.alu_src          = 1'b1;
                w_illegal            = (w_f3 != 3'b000);
            end
            c_OPC_BRANCH: begin
                w_c.branch_enable = 1'b1;
                w_c.branch_mode   = w_f3;
                w_c.alu_op        = c_ALU_SUB;
                w_illegal         = (w_f3[2:1] == 2'b01);
            end
            c_OPC_LOAD: begin
                w_c.reg_write_enable = 1'b1;
                w_c.mem_to_reg       = 1'b1;
                w_c.alu_src          = 1'b1;
                w_c.mem_mode         = w_f3[1:0];
                w_c.mem_unsigned     = w_f3[2];
                case (w_f3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_illegal = 1'b0;
                    3'b110:  w_illegal = (LWU_LEGAL == 0);
                    default: w_illegal = 1'b1;
                endcase
            end
            c_OPC_STORE: begin
                w_c.mem_write_enable = 1'b1;
                w_c.alu_src          = 1'b1;
                w_c.mem_mode         = w_f3[1:0];
                w_illegal            = (w_f3 > 3'b010);
            end
            c_OPC_IMM: begin
                w_c.reg_write_enable = 1'b1;
                w_c.alu_src          = 1'b1;
                w_c.alu_op           = alu_from_f3(w_f3, (w_f3 == 3'b101) && w_f7[5]);
                if (w_f3 == 3'b001)
                    w_illegal = (w_f7 != 7'b0000000);
                else if (w_f3 == 3'b101)
                    w_illegal = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
            end
            c_OPC_REG: begin
                w_c.reg_write_enable = 1'b1;
                if (w_f7 == 7'b0000000)
                    w_c.alu_op = alu_from_f3(w_f3, 1'b0);
                else if (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))
                    w_c.alu_op = alu_from_f3(w_f3, 1'b1);
`ifdef CONTROL_PIPE_RV32M_EN
                else if (w_f7 == 7'b0000001) begin
                    w_c.muldiv_en = 1'b1;
                    w_c.muldiv_op = w_f3;
                    w_c.alu_op    = c_ALU_ADD;
                end
`endif
                else
                    w_illegal = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal)
            w_c = '0;
    end

    assign ctrl                 = w_c;
    assign illegal              = w_illegal;
    assign {rs1_used, rs2_used} = rs_usage(w_opcode);
    assign rd                   = w_c.reg_write_enable ? instr[11:7] : 5'd0;
    assign rs1                  = instr[19:15];
    assign rs2                  = instr[24:20];

endmodule
`default_nettype wire

// File: rtl/control_pipe.sv
`default_nettype none
// ============================================================================
// Module  : control_pipe
// Brief   : Registered RV32I decode stage with load-use interlock, flush,
//           sticky illegal-instruction trap and saturating bubble counter.
//           CONTROL_PIPE_RV32M_EN enables M-extension decode.
// Revision: 1.0 - initial registered decode stage release
// ============================================================================
module control_pipe
    import control_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int CNT_W     = 16,
    parameter int LWU_LEGAL = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid,
    output logic                if_ready,
    input  logic [31:0]         if_instr,
    input  logic [XLEN-1:0]     if_pc,
    input  logic                flush,
    input  logic                ex_ready,
    output logic                ex_valid,
    output logic [c_CTRL_W-1:0] ex_ctrl,
    output logic [4:0]          ex_rd,
    output logic [4:0]          ex_rs1,
    output logic [4:0]          ex_rs2,
    output logic [XLEN-1:0]     ex_pc,
    output logic [31:0]         ex_instr,
    output logic                trap_pending,
    output logic [XLEN-1:0]     trap_pc,
    output logic [31:0]         trap_instr,
    input  logic                trap_ack,
    output logic [CNT_W-1:0]    bubble_count
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    ctrl_t            w_dec_ctrl;
    logic [4:0]       w_dec_rd;
    logic [4:0]       w_dec_rs1;
    logic [4:0]       w_dec_rs2;
    logic             w_rs1_used;
    logic             w_rs2_used;
    logic             w_illegal;
    logic             w_advance;
    logic             w_hazard;
    logic             w_accept;

    logic             r_ex_valid;
    ctrl_t            r_ex_ctrl;
    logic [4:0]       r_ex_rd;
    logic [4:0]       r_ex_rs1;
    logic [4:0]       r_ex_rs2;
    logic [XLEN-1:0]  r_ex_pc;
    logic [31:0]      r_ex_instr;
    logic             r_trap_pending;
    logic [XLEN-1:0]  r_trap_pc;
    logic [31:0]      r_trap_instr;
    logic [CNT_W-1:0] r_bubble_count;

    control_decode #(
        .LWU_LEGAL (LWU_LEGAL)
    ) u_decode (
        .instr    (if_instr),
        .ctrl     (w_dec_ctrl),
        .rd       (w_dec_rd),
        .rs1      (w_dec_rs1),
        .rs2      (w_dec_rs2),
        .rs1_used (w_rs1_used),
        .rs2_used (w_rs2_used),
        .illegal  (w_illegal)
    );

    // ex_rd is already zero for non-writing slots, so stores/branches never stall.
    assign w_advance = !r_ex_valid || ex_ready;
    assign w_hazard  = r_ex_valid && r_ex_ctrl.mem_to_reg && (r_ex_rd != 5'd0) &&
                       ((w_rs1_used && (w_dec_rs1 == r_ex_rd)) ||
                        (w_rs2_used && (w_dec_rs2 == r_ex_rd)));
    assign w_accept  = if_valid && !w_hazard && !r_trap_pending;
    assign if_ready  = flush || (w_advance && !w_hazard && !r_trap_pending);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid     <= 1'b0;
            r_ex_ctrl      <= '0;
            r_ex_rd        <= '0;
            r_ex_rs1       <= '0;
            r_ex_rs2       <= '0;
            r_ex_pc        <= '0;
            r_ex_instr     <= '0;
            r_trap_pending <= 1'b0;
            r_trap_pc      <= '0;
            r_trap_instr   <= '0;
            r_bubble_count <= '0;
        end else begin
            if (flush) begin
                r_ex_valid <= 1'b0;
            end else if (w_advance) begin
                r_ex_valid <= 1'b0;
                if (if_valid && w_hazard) begin
                    if (r_bubble_count != c_CNT_MAX)
                        r_bubble_count <= r_bubble_count + 1'b1;
                end else if (w_accept) begin
                    r_ex_pc    <= if_pc;
                    r_ex_instr <= if_instr;
                    if (w_illegal) begin
                        r_trap_pending <= 1'b1;
                        r_trap_pc      <= if_pc;
                        r_trap_instr   <= if_instr;
                        r_ex_ctrl      <= '0;
                        r_ex_rd        <= '0;
                        r_ex_rs1       <= '0;
                        r_ex_rs2       <= '0;
                    end else begin
                        r_ex_valid <= 1'b1;
                        r_ex_ctrl  <= w_dec_ctrl;
                        r_ex_rd    <= w_dec_rd;
                        r_ex_rs1   <= w_dec_rs1;
                        r_ex_rs2   <= w_dec_rs2;
                    end
                end
            end
            // Capture needs !trap_pending, so this never races a new capture.
            if (trap_ack && r_trap_pending)
                r_trap_pending <= 1'b0;
        end
    end

    assign ex_valid     = r_ex_valid;
    assign ex_ctrl      = r_ex_ctrl;
    assign ex_rd        = r_ex_rd;
    assign ex_rs1       = r_ex_rs1;
    assign ex_rs2       = r_ex_rs2;
    assign ex_pc        = r_ex_pc;
    assign ex_instr     = r_ex_instr;
    assign trap_pending = r_trap_pending;
    assign trap_pc      = r_trap_pc;
    assign trap_instr   = r_trap_instr;
    assign bubble_count = r_bubble_count;

endmodule
`default_nettype wire

// File: tb/tb_control_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_control_pipe
// Brief   : Self-checking bench for control_pipe: directed scenarios followed
//           by randomized traffic against a behavioural reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_control_pipe;

    localparam int CNT_W   = 4;
    localparam int BUB_MAX = (1 << CNT_W) - 1;
`ifdef CONTROL_PIPE_RV32M_EN
    localparam bit RV32M = 1'b1;
`else
    localparam bit RV32M = 1'b0;
`endif
    localparam logic [3:0] ALU_TAB [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             if_valid = 1'b0;
    logic             if_ready;
    logic [31:0]      if_instr = '0;
    logic [31:0]      if_pc = '0;
    logic             flush = 1'b0;
    logic             ex_ready = 1'b0;
    logic             ex_valid;
    logic [21:0]      ex_ctrl;
    logic [4:0]       ex_rd, ex_rs1, ex_rs2;
    logic [31:0]      ex_pc, ex_instr;
    logic             trap_pending;
    logic [31:0]      trap_pc, trap_instr;
    logic             trap_ack = 1'b0;
    logic [CNT_W-1:0] bubble_count;

    control_pipe #(.XLEN(32), .CNT_W(CNT_W), .LWU_LEGAL(0)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_instr(ex_instr),
        .trap_pending(trap_pending), .trap_pc(trap_pc), .trap_instr(trap_instr),
        .trap_ack(trap_ack), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the execute stage should be holding.
    bit          m_valid, m_is_load, m_trap, m_ready;
    logic [21:0] m_ctrl;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [31:0] m_pc, m_instr, m_tpc, m_tinstr;
    int          m_bub;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bundle packed in listed field order, MSB first.
    function automatic void ref_decode(input logic [31:0] ins, output bit ill, output bit u1,
                                       output bit u2, output bit wr, output logic [21:0] ctrl);
        bit [6:0] op = ins[6:0];
        bit [2:0] f3 = ins[14:12];
        bit [6:0] f7 = ins[31:25];
        bit       be = 0, mw = 0, mu = 0, rw = 0, m2r = 0, asrc = 0, p2r = 0, je = 0, jr = 0, md = 0;
        bit [2:0] bm = 0, mop = 0;
        bit [1:0] mm = 0;
        bit [3:0] alu = 0;
        ill = 0;
        u1  = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
        u2  = (op == 7'b1100011 || op == 7'b0100011 || op == 7'b0110011);
        case (op)
            7'b0110111: begin rw = 1; asrc = 1; alu = 4'd10; end
            7'b0010111: begin rw = 1; asrc = 1; end
            7'b1101111: begin rw = 1; p2r = 1; je = 1; end
            7'b1100111: begin rw = 1; p2r = 1; je = 1; jr = 1; asrc = 1; ill = (f3 != 0); end
            7'b1100011: begin be = 1; bm = f3; alu = 4'd1; ill = (f3 == 2 || f3 == 3); end
            7'b0000011: begin
                rw = 1; m2r = 1; asrc = 1; mm = f3[1:0]; mu = f3[2];
                ill = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            end
            7'b0100011: begin mw = 1; asrc = 1; mm = f3[1:0]; ill = (f3 > 2); end
            7'b0010011: begin
                rw = 1; asrc = 1; alu = ALU_TAB[f3];
                if (f3 == 1) ill = (f7 != 0);
                if (f3 == 5) begin
                    if (f7 == 7'h20) alu = 4'd7;
                    else ill = (f7 != 0);
                end
            end
            7'b0110011: begin
                rw = 1;
                if (f7 == 0) alu = ALU_TAB[f3];
                else if (f7 == 7'h20 && f3 == 0) alu = 4'd1;
                else if (f7 == 7'h20 && f3 == 5) alu = 4'd7;
                else if (f7 == 7'h01 && RV32M) begin md = 1; mop = f3; end
                else ill = 1;
            end
            default: ill = 1;
        endcase
        wr   = rw && !ill;
        ctrl = ill ? 22'd0 : {be, bm, mw, mu, mm, rw, m2r, alu, asrc, p2r, je, jr, md, mop};
    endfunction

    task automatic check_outputs();
        check_val("ex_valid", ex_valid, m_valid);
        check_val("trap_pending", trap_pending, m_trap);
        check_val("bubble_count", bubble_count, m_bub);
        if (m_valid) begin
            check_val("ex_ctrl", ex_ctrl, m_ctrl);
            check_val("ex_rd", ex_rd, m_rd);
            check_val("ex_rs1", ex_rs1, m_rs1);
            check_val("ex_rs2", ex_rs2, m_rs2);
            check_val("ex_pc", ex_pc, m_pc);
            check_val("ex_instr", ex_instr, m_instr);
        end
        if (m_trap) begin
            check_val("trap_pc", trap_pc, m_tpc);
            check_val("trap_instr", trap_instr, m_tinstr);
        end
    endtask

    // One clock: drive, check if_ready, advance model by the priority rules, check.
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit fl, input bit er, input bit ack);
        bit ill, u1, u2, wr, adv, haz, old_trap;
        logic [21:0] c;
        if_valid = v; if_instr = ins; if_pc = pc; flush = fl; ex_ready = er; trap_ack = ack;
        ref_decode(ins, ill, u1, u2, wr, c);
        adv = !m_valid || er;
        haz = m_valid && m_is_load && (m_rd != 0) &&
              ((u1 && ins[19:15] == m_rd) || (u2 && ins[24:20] == m_rd));
        m_ready = fl || (adv && !haz && !m_trap);
        #1;
        check_val("if_ready", if_ready, m_ready);
        @(posedge clk);
        #1;
        old_trap = m_trap;
        if (fl) m_valid = 0;
        else if (adv) begin
            m_valid = 0;
            if (v && haz) begin
                if (m_bub < BUB_MAX) m_bub++;
            end else if (v && !m_trap) begin
                if (ill) begin
                    m_trap = 1; m_tpc = pc; m_tinstr = ins;
                end else begin
                    m_valid = 1; m_is_load = (ins[6:0] == 7'b0000011); m_ctrl = c;
                    m_rd = wr ? ins[11:7] : 5'd0; m_rs1 = ins[19:15]; m_rs2 = ins[24:20];
                    m_pc = pc; m_instr = ins;
                end
            end
        end
        if (ack && old_trap) m_trap = 0;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1; if_valid = 0; flush = 0; ex_ready = 0; trap_ack = 0;
        #1;
        check_val("rst_ex_valid", ex_valid, 0);
        check_val("rst_ex_ctrl", ex_ctrl, 0);
        check_val("rst_ex_rd", ex_rd, 0);
        check_val("rst_ex_pc", ex_pc, 0);
        check_val("rst_ex_instr", ex_instr, 0);
        check_val("rst_trap", trap_pending, 0);
        check_val("rst_trap_pc", trap_pc, 0);
        check_val("rst_bub", bubble_count, 0);
        m_valid = 0; m_is_load = 0; m_trap = 0; m_ctrl = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
        m_pc = 0; m_instr = 0; m_tpc = 0; m_tinstr = 0; m_bub = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd = 5'($urandom_range(0, 3));
        logic [4:0]  r1 = 5'($urandom_range(0, 3));
        logic [4:0]  r2 = 5'($urandom_range(0, 3));
        logic [2:0]  f3 = 3'($urandom_range(0, 7));
        logic [31:0] r  = $urandom;
        logic [6:0]  f7;
        case ($urandom_range(0, 3))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            default: f7 = ($urandom_range(0, 1) == 1) ? 7'h01 : r[31:25];
        endcase
        case ($urandom_range(0, 11))
            0:       return {r[31:12], rd, 7'b0110111};
            1:       return {r[31:12], rd, 7'b0010111};
            2:       return {r[31:12], rd, 7'b1101111};
            3:       return {r[31:20], r1, (($urandom_range(0, 3) == 0) ? f3 : 3'b000), rd, 7'b1100111};
            4:       return {r[31:25], r2, r1, f3, r[11:7], 7'b1100011};
            5, 6:    return {r[31:20], r1, f3, rd, 7'b0000011};
            7:       return {r[31:25], r2, r1, f3, r[11:7], 7'b0100011};
            8:       return {f7, r[24:20], r1, f3, rd, 7'b0010011};
            9, 10:   return {f7, r2, r1, f3, rd, 7'b0110011};
            default: return r;
        endcase
    endfunction

    initial begin
        bit          have;
        logic [31:0] cur, cur_pc, pc_ctr;
        #2;
        do_reset();

        // ADDI x1,x0,5
        step(1, 32'h00500093, 32'h0, 0, 1, 0);
        check_val("addi_valid", ex_valid, 1);
        check_val("addi_alu", ex_ctrl[11:8], 4'd0);
        check_val("addi_src", ex_ctrl[7], 1);
        check_val("addi_we", ex_ctrl[13], 1);
        check_val("addi_rd", ex_rd, 1);

        // LW x2,0(x1) then ADD x3,x2,x2: one bubble
        step(1, 32'h0000A103, 32'h4, 0, 1, 0);
        step(1, 32'h002101B3, 32'h8, 0, 1, 0);
        check_val("lu_bubble_valid", ex_valid, 0);
        step(1, 32'h002101B3, 32'h8, 0, 1, 0);
        check_val("lu_add_issued", ex_pc, 32'h8);
        check_val("lu_bubble_cnt", bubble_count, 1);

        // Backpressure: ADD held for three cycles, ADDI x4 accepted on release
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h00100213, 32'hC, 0, 0, 0);
            check_val("stall_pc", ex_pc, 32'h8);
        end
        step(1, 32'h00100213, 32'hC, 0, 1, 0);
        check_val("stall_release_pc", ex_pc, 32'hC);

        // Illegal instruction trap, blocked until acknowledged
        step(1, 32'hFFFFFFFF, 32'h40, 0, 1, 0);
        check_val("trap_set", trap_pending, 1);
        check_val("trap_pc_0x40", trap_pc, 32'h40);
        step(1, 32'h00500093, 32'h44, 0, 1, 0);
        step(1, 32'h00500093, 32'h44, 0, 1, 1);
        step(1, 32'h00500093, 32'h44, 0, 1, 0);
        check_val("trap_resume", ex_valid, 1);

        // Flush while ADD is hazard-stalled behind a load
        step(1, 32'h0000A103, 32'h48, 0, 1, 0);
        step(1, 32'h002101B3, 32'h4C, 1, 1, 0);
        check_val("flush_valid", ex_valid, 0);
        check_val("flush_bub", bubble_count, 1);
        step(0, 32'h0, 32'h0, 0, 1, 0);

        // MUL x5,x6,x7
        step(1, 32'h027302B3, 32'h50, 0, 1, 0);
        if (RV32M) begin
            check_val("mul_en", ex_ctrl[3], 1);
            check_val("mul_op", ex_ctrl[2:0], 0);
        end else begin
            check_val("mul_trap", trap_pending, 1);
        end
        step(0, 32'h0, 32'h0, 0, 1, 1);

        // Saturate the bubble counter
        for (int i = 0; i < BUB_MAX + 2; i++) begin
            step(1, 32'h0000A103, 32'h60, 0, 1, 0);
            step(1, 32'h002101B3, 32'h64, 0, 1, 0);
            step(1, 32'h002101B3, 32'h64, 0, 1, 0);
        end
        check_val("bub_saturated", bubble_count, BUB_MAX);

        // Asynchronous reset mid-operation
        step(1, 32'h00500093, 32'h70, 0, 1, 0);
        do_reset();

        // Randomized traffic
        have = 0; cur = 0; cur_pc = 0; pc_ctr = 32'h1000;
        for (int i = 0; i < 4000; i++) begin
            if (!have && $urandom_range(0, 9) < 8) begin
                cur = rand_instr(); cur_pc = pc_ctr; pc_ctr += 4; have = 1;
            end
            step(have, have ? cur : $urandom, cur_pc,
                 ($urandom_range(0, 24) == 0), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 3) == 0));
            if (have && m_ready) have = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_pipe.md
Name: control_pipe

Overview:
- Registered RV32I decode stage; successor to the combinational control decoder.
- Takes fetched instruction + PC over a valid/ready handshake, decodes it and presents a registered control bundle to the execute stage.
- Adds load-use interlock (bubble insertion), synchronous flush, sticky illegal-instruction trap capture and a saturating bubble counter.
- Sits between the IF/ID and ID/EX boundaries and replaces the separate stall input with backpressure.

Parameters:
- XLEN, 32, PC width.
- CNT_W, 16, bubble counter width.
- LWU_LEGAL, 0, 1 = funct3 110 load decodes as unsigned word load; 0 = illegal.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- if_valid  in  1  instruction offered
- if_ready  out  1  instruction accepted this cycle when high with if_valid
- if_instr  in  32  instruction word
- if_pc  in  XLEN  instruction PC
- flush  in  1  discard held/incoming instruction (branch taken downstream)
- ex_ready  in  1  execute stage can accept
- ex_valid  out  1  control bundle valid
- ex_ctrl  out  22  packed bundle: branch_enable, branch_mode[2:0], mem_write_enable, mem_unsigned, mem_mode[1:0], reg_write_enable, mem_to_reg, alu_op[3:0], alu_src, pc_to_reg, jump_enable, jump_reg, muldiv_en, muldiv_op[2:0]
- ex_rd, ex_rs1, ex_rs2  out  5 each  register indices
- ex_pc  out  XLEN  PC of bundle
- ex_instr  out  32  raw instruction (immediate generation downstream)
- trap_pending  out  1  illegal instruction captured
- trap_pc  out  XLEN  PC of illegal instruction
- trap_instr  out  32  illegal instruction word
- trap_ack  in  1  clears trap_pending
- bubble_count  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset: all outputs 0; ex_valid=0, trap_pending=0, bubble_count=0.
- Latency: one cycle from accept to ex_valid.
- advance = !ex_valid || ex_ready.
- hazard = ex_valid && ex_ctrl.mem_to_reg && ex_rd!=0 && ((rs1 used && if_rs1==ex_rd) || (rs2 used && if_rs2==ex_rd)).
  - rs1 used: all except LUI, AUIPC, JAL.
  - rs2 used: branch, store, R-type.
- if_ready = flush || (advance && !hazard && !trap_pending).
- Priority per clock edge:
  1. flush: ex_valid<=0, input consumed and discarded.
  2. advance && hazard && if_valid: ex_valid<=0 (bubble), input held, bubble_count++ (saturate at all-ones).
  3. advance && accept of legal instruction: register bundle, ex_valid<=1.
  4. advance && accept of illegal instruction: ex_valid<=0, trap_pending<=1, trap_pc/trap_instr captured.
  5. advance && !if_valid: ex_valid<=0.
  6. !advance: outputs hold.
- Decoding is identical to the existing control mapping for all RV32I groups (LUI, AUIPC, JAL, JALR, branches, loads, stores, OP-IMM, OP); any other encoding is illegal.
- Illegal-slot bundle fields are 0.
- trap_pending blocks further accepts until trap_ack. Same-cycle trap_ack and new trap capture cannot occur, because capture requires !trap_pending. trap_ack while trap_pending=0 is ignored. flush does not clear trap_pending.
- ex_rd is forced to 0 when reg_write_enable=0, so the hazard check never fires on stores or branches.
- Reset mid-operation: immediate return to reset values; any in-flight instruction is lost.

Optional Feature:
- Macro CONTROL_PIPE_RV32M_EN.
- Defined: opcode 0110011 with funct7 0000001 is legal; sets muldiv_en=1, muldiv_op=funct3, reg_write_enable=1, alu_op=0.
- Undefined: these encodings are illegal and raise the trap; muldiv_en/muldiv_op are constant 0.

Decomposition:
- Package control_pkg holds:
  - opcode group constants;
  - ALU codes, comparison codes and memory mode codes;
  - the packed control bundle typedef and its width;
  - an rs-usage helper function.
- Sub-module control_decode: purely combinational instruction → {bundle, rs1_used, rs2_used, illegal}, honouring LWU_LEGAL and the macro.
- control_pipe owns the handshake, hazard, trap and counter logic.

Test Plan:
- ADDI x1,x0,5 (0x00500093) offered with ex_ready=1 → next cycle ex_valid=1, alu_op=ALU_ADD, alu_src=1, reg_write_enable=1, ex_rd=1.
- LW x2,0(x1), then ADD x3,x2,x2 back-to-back, ex_ready=1 → one cycle ex_valid=0, if_ready=0, then ADD issues; bubble_count=1.
- ex_ready=0 for 3 cycles while if_valid=1 → ex_* stable, if_ready=0; ex_ready=1 → next instruction accepted on the same edge.
- Instruction 0xFFFFFFFF at PC 0x40 → trap_pending=1, trap_pc=0x40, ex_valid=0, if_ready=0 until trap_ack pulse, then accepts resume.
- flush asserted while holding a hazard-stalled ADD → ADD discarded, ex_valid=0, bubble_count unchanged; counter forced near max saturates at 2^CNT_W−1.
- MUL x5,x6,x7 (0x027302B3) → with macro: muldiv_en=1, muldiv_op=0; without macro: trap_pending=1.
